// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, access-memory-pattern
// (amp) byte-mask constants and the amp legality rule.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'b00,
        DMR_WAIT = 2'b01,
        DMR_RESP = 2'b10
    } dmr_state_e;

    localparam logic [3:0] AMP_WORD    = 4'b1111;
    localparam logic [3:0] AMP_HALF_LO = 4'b0011;
    localparam logic [3:0] AMP_HALF_HI = 4'b1100;

    // Word, aligned halfword, or single byte; anything else is a misaligned access.
    function automatic logic amp_is_legal(input logic [3:0] amp);
        case (amp)
            AMP_WORD, AMP_HALF_LO, AMP_HALF_HI,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_amp_check.sv
// Combinational legality check for a memory access: amp pattern must be legal and the
// word index must fall inside the storage. Shared with the core's misalignment trap logic.
module dmem_responder_amp_check
    import dmem_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic [3:0]      amp,
    input  logic [XLEN-3:0] word_index,
    output logic            legal
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // DEPTH_WORDS is a power of two, so in range means no index bits above AW are set.
    always_comb begin
        legal = amp_is_legal(amp) && ((word_index >> AW) == '0);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte-lane-masked
// store or full-word load, response held until the requester accepts it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_amp,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmr_state_e       state, state_next;
    logic [3:0]       wait_cnt;
    logic             lat_we;
    logic [XLEN-3:0]  lat_index;
    logic [XLEN-1:0]  lat_wdata;
    logic [3:0]       lat_amp;

    logic             req_fire, rsp_fire, do_access;
    logic             acc_we, acc_legal;
    logic [XLEN-3:0]  acc_index;
    logic [XLEN-1:0]  acc_wdata;
    logic [3:0]       acc_amp;

    logic [XLEN-1:0]  mem [DEPTH_WORDS];

    // Lane position travels in req_amp, so the byte offset bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // A zero-wait build accesses in the accept cycle, straight from the live request.
    always_comb begin
        if (state == DMR_IDLE) begin
            acc_we    = req_we;
            acc_index = req_addr[XLEN-1:2];
            acc_wdata = req_wdata;
            acc_amp   = req_amp;
        end else begin
            acc_we    = lat_we;
            acc_index = lat_index;
            acc_wdata = lat_wdata;
            acc_amp   = lat_amp;
        end
    end

    dmem_responder_amp_check #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_amp_check (
        .amp        (acc_amp),
        .word_index (acc_index),
        .legal      (acc_legal)
    );

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= DMR_IDLE;
        else        state <= state_next;
    end

    // NOTE: each comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            DMR_IDLE: if (req_fire) state_next = (WAIT_CYCLES == 0) ? DMR_RESP : DMR_WAIT;
            DMR_WAIT: if (wait_cnt == 4'd0) state_next = DMR_RESP;
            DMR_RESP: if (rsp_fire) state_next = DMR_IDLE;
            default:  state_next = DMR_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        do_access = 1'b0;
        case (state)
            DMR_IDLE: begin
                req_ready = reset;
                do_access = req_valid && reset && (WAIT_CYCLES == 0);
            end
            DMR_WAIT: do_access = (wait_cnt == 4'd0);
            DMR_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_index <= '0;
            lat_wdata <= '0;
            lat_amp   <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                lat_we    <= req_we;
                lat_index <= req_addr[XLEN-1:2];
                lat_wdata <= req_wdata;
                lat_amp   <= req_amp;
                wait_cnt  <= WAIT_INIT;
            end else if (state == DMR_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (do_access) begin
                rsp_err   <= !acc_legal;
                rsp_rdata <= (acc_legal && !acc_we) ? mem[acc_index[AW-1:0]] : '0;
            end
        end
    end

    // NOTE: storage is deliberately not reset; it stays a plain RAM for FPGA inference.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && acc_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_amp[i]) mem[acc_index[AW-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder, plus a short directed run on a zero-wait build.
module tb_dmem_responder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_amp;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_amp;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_amp(req_amp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_amp(z_req_amp),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hold_low = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          accept_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_amp(input logic [3:0] a);
        return a inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    // Reference behaviour: a word-addressed array with byte-masked merge on stores.
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] amp, output exp_t e);
        int unsigned idx;
        logic [31:0] m;
        idx = addr >> 2;
        e.rdata = 32'h0;
        e.err = 1'b0;
        e.accept_cyc = 0;
        if (!legal_amp(amp) || idx >= DEPTH) begin
            e.err = 1'b1;
        end else if (we) begin
            m = 32'h0;
            for (int i = 0; i < 4; i++) if (amp[i]) m = m | (32'hFF << (8 * i));
            ref_mem[idx] = (ref_mem[idx] & ~m) | (wdata & m);
        end else begin
            e.rdata = ref_mem[idx];
        end
    endtask

    // Called at a negedge; returns at the negedge after the request is accepted.
    task automatic send(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] amp);
        int   n;
        exp_t e;
        req_we = we; req_addr = addr; req_wdata = wdata; req_amp = amp; req_valid = 1'b1;
        n = 0;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", req_ready, 1);
        end else begin
            model(we, addr, wdata, amp, e);
            e.accept_cyc = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_amp = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        #1;
        while ((sb.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk); #1; n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Zero-wait build: response must be valid at the first negedge after the accept edge.
    task automatic z_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] amp, input logic [31:0] exp_rdata, input logic exp_err);
        z_req_we = we; z_req_addr = addr; z_req_wdata = wdata; z_req_amp = amp; z_req_valid = 1'b1;
        #1;
        check("z_req_ready_idle", z_req_ready, 1);
        @(negedge clk);
        z_req_valid = 1'b0;
        #1;
        check("z_rsp_valid_next_cycle", z_rsp_valid, 1);
        check("z_rsp_rdata", z_rsp_rdata, exp_rdata);
        check("z_rsp_err", z_rsp_err, exp_err);
        @(negedge clk);
        #1;
        check("z_rsp_valid_cleared", z_rsp_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && hold_low > 0) begin
                rsp_ready = 1'b0;
                hold_low--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each response handshake and checks protocol timing.
    initial begin
        bit          prev_stall, prev_fire, prev_valid;
        logic [31:0] prev_rdata;
        logic        prev_err;
        exp_t        e;
        prev_stall = 0; prev_fire = 0; prev_valid = 0; prev_rdata = 0; prev_err = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                prev_stall = 0; prev_fire = 0; prev_valid = 0;
                continue;
            end
            if (rsp_valid) check("req_ready_low_in_resp", req_ready, 0);
            if (prev_stall) begin
                check("rsp_valid_held", rsp_valid, 1);
                check("rsp_rdata_held", rsp_rdata, prev_rdata);
                check("rsp_err_held", rsp_err, prev_err);
            end
            if (prev_fire) begin
                check("rsp_valid_drop_after_hs", rsp_valid, 0);
                check("req_ready_after_hs", req_ready, 1);
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 0);
                else check("rsp_latency", cyc, sb[0].accept_cyc + WAITC);
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_fire  = rsp_valid && rsp_ready;
            prev_valid = rsp_valid;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legal_list [7];
        logic [31:0] a;
        legal_list = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_amp = 0;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_amp = 0;
        z_rsp_ready = 1'b1;

        #3;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("req_ready_after_reset", req_ready, 1);
        check("z_req_ready_after_reset", z_req_ready, 1);

        for (int i = 0; i < 16; i++) send(1'b1, 32'(i * 4), 32'h0, 4'b1111);

        send(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        send(1'b0, 32'h10, 32'h0, 4'b1111);
        send(1'b1, 32'h12, 32'h00AA0000, 4'b0100);
        send(1'b0, 32'h10, 32'h0, 4'b1111);
        send(1'b1, 32'h10, 32'h12340000, 4'b1100);
        send(1'b0, 32'h10, 32'h0, 4'b0001);

        drain();
        hold_low = 3;
        send(1'b0, 32'h10, 32'h0, 4'b1111);
        drain();

        send(1'b1, 32'h400, 32'h55555555, 4'b1111);
        send(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111);
        send(1'b1, 32'h20, 32'h11111111, 4'b0101);
        send(1'b0, 32'h20, 32'h0, 4'b1111);
        drain();

        // Store aborted by reset during WAIT must leave storage untouched.
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_amp = 4'b1111;
        req_valid = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready_in_reset", req_ready, 0);
        check("abort_rsp_rdata", rsp_rdata, 0);
        check("abort_rsp_err", rsp_err, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        send(1'b0, 32'h30, 32'h0, 4'b1111);
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255) << 2);
            else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), a, $urandom,
                 ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_list[$urandom_range(0, 6)]);
        end
        drain();

        z_txn(1'b1, 32'h8, 32'hA5A55A5A, 4'b1111, 32'h0, 1'b0);
        z_txn(1'b0, 32'h8, 32'h0, 4'b0001, 32'hA5A55A5A, 1'b0);
        z_txn(1'b1, 32'h9, 32'h0000C300, 4'b0010, 32'h0, 1'b0);
        z_txn(1'b0, 32'h8, 32'h0, 4'b1111, 32'hA5A5C35A, 1'b0);
        z_txn(1'b0, 32'h8, 32'h0, 4'b0110, 32'h0, 1'b1);
        z_txn(1'b0, 32'h800, 32'h0, 4'b1111, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (slave) for the core's load/store port: accepts one request at a time over a valid/ready handshake.
- Applies a configurable number of wait states, then performs a byte-lane-masked write or a full-word read, and returns a response over a second valid/ready handshake.
- It is the memory end of the interface whose CPU end generates the access-memory-pattern (amp) byte mask.
- Used in simulation and FPGA builds as the data memory behind the pipeline's MEM stage.

Parameters:
XLEN, 32, data/address width
DEPTH_WORDS, 256, number of 32-bit words in storage (power of two)
WAIT_CYCLES, 2, wait states between request accept and memory access (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address; bits [1:0] ignored (lane position is carried by req_amp)
req_wdata  input  XLEN  store data, already lane-aligned
req_amp  input  4  byte enables; bit i selects bits [8i+7:8i]
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  XLEN  read word (raw, unextended); 0 for stores and errors
rsp_err  output  1  request was illegal; no memory side effect

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - req_ready=1 once reset is released.
  - Storage contents are not reset.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- IDLE:
  - On req_valid&&req_ready at edge t0, latch we/addr/wdata/amp.
  - If WAIT_CYCLES==0, perform the access at t0 and go to RESP.
  - Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 0, perform the access and go to RESP.
  - The access therefore occurs at edge t0+WAIT_CYCLES, and rsp_valid is high in the following cycle.
- Access on the latched request:
  - Legal amp values: 1111, 0011, 1100, 0001, 0010, 0100, 1000.
  - Word index = addr[31:2]; out of range if the index is >= DEPTH_WORDS.
  - Illegal amp or out of range: no write; rsp_err=1, rsp_rdata=0.
  - Legal store: write only the enabled byte lanes; rsp_rdata=0, rsp_err=0.
  - Legal load: rsp_rdata = full stored word, independent of amp; rsp_err=0.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE.
  - At least one IDLE cycle separates transactions; there is no pipelining.
- Requests presented while not in IDLE are ignored. The requester must hold req_valid until it sees req_ready.
- Reset mid-operation:
  - In WAIT, the transaction is aborted and no write occurs.
  - In RESP, the response is dropped; a write already committed stays committed.
- An address read after being written in an earlier transaction returns the new data; there is no read-during-write case, since only one access is ever in flight.

Decomposition:
- Shared defines file:
  - State encodings DMR_IDLE/DMR_WAIT/DMR_RESP (2-bit).
  - AMP_WORD=4'b1111, AMP_HALF_LO=4'b0011, AMP_HALF_HI=4'b1100.
- One natural sub-module: amp_check, combinational: amp and word index in -> legal flag out. Reused by the core for misalignment trapping.
- Byte-lane write and wait counter live in the top module.

Test Plan (WAIT_CYCLES=2, DEPTH_WORDS=256):
- Store addr=0x10, wdata=0xDEADBEEF, amp=1111, accepted at edge t0 -> rsp_valid high after edge t0+2, rsp_err=0, rsp_rdata=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
- Store addr=0x12, wdata=0x00AA0000, amp=0100, then load 0x10 -> 0xDEAABEEF. Then store amp=1100, wdata=0x12340000 -> load gives 0x1234BEEF.
- Load with rsp_ready held low for 3 cycles after rsp_valid rises -> rsp_valid/rsp_rdata stable all 3 cycles; req_ready=0 throughout; IDLE resumes one cycle after the handshake.
- Store addr=0x400 (index 256) -> rsp_err=1, no write. Store addr=0x20, amp=0101 -> rsp_err=1, and a subsequent load of 0x20 returns its prior value.
- Store 0xFFFFFFFF to 0x30 (prior value 0x0) with reset pulsed low during WAIT -> outputs return to reset values asynchronously; a subsequent load of 0x30 returns 0x00000000.
- WAIT_CYCLES=0 build: load accepted at t0 -> rsp_valid high in the cycle after t0, with correct data.
